// File: rtl/spi_frame_assembler_pkg.sv
// Shared constants, FSM state type and checksum arithmetic for the frame assembler.
// The bench imports this package as well.
package spi_frame_assembler_pkg;

  localparam int NUM_CH = 64;
  localparam int DATA_W = 11;
  localparam int ADDR_W = $clog2(NUM_CH);
  localparam logic [DATA_W-1:0] SYNC_WORD = 11'h7FF;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK,
    COMMIT
  } state_t;

  // Running frame checksum: plain sum of channel words, wrapping at 2^DATA_W.
  function automatic logic [DATA_W-1:0] checksum_add(input logic [DATA_W-1:0] sum,
                                                     input logic [DATA_W-1:0] word);
    return sum + word;
  endfunction

endpackage

// File: rtl/spi_frame_assembler_if.sv
// Word input and channel-write output bundle between receiver, assembler and organizer.
interface spi_frame_assembler_if;
  import spi_frame_assembler_pkg::*;

  logic [DATA_W-1:0] word_in;
  logic              word_valid;
  logic [ADDR_W-1:0] ch_addr;
  logic [DATA_W-1:0] ch_data;
  logic              ch_we;
  logic              frame_done;
  logic              frame_err;
  logic              busy;

  modport master (
    output word_in, word_valid,
    input  ch_addr, ch_data, ch_we, frame_done, frame_err, busy
  );

  modport slave (
    input  word_in, word_valid,
    output ch_addr, ch_data, ch_we, frame_done, frame_err, busy
  );

endinterface

// File: rtl/spi_frame_assembler_frame_buffer_ram.sv
// NUM_CH x DATA_W simple dual-port frame buffer: one write port, one registered read port.
module frame_buffer_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 11,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/spi_frame_assembler.sv
// Collects sync + NUM_CH channel words + checksum, and replays the buffered frame
// to the channel organizer only once the checksum matches.
module spi_frame_assembler
  import spi_frame_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_frame_assembler_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] cksum;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] rd_addr;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              done_pend;
  logic              word_is_sync;
  logic              wr_en;
  logic              ck_en;

  assign word_is_sync = (bus.word_in == SYNC_WORD);
  assign wr_en = (state == RECV) && bus.word_valid && (count != FULL_CNT) && !word_is_sync;
  assign ck_en = (state == RECV) && bus.word_valid && (count == FULL_CNT);

  // Read one entry ahead so ch_data is registered in the same cycle as ch_addr.
  assign rd_addr = (state == COMMIT) ? ptr + 1'b1 : '0;

  frame_buffer_ram #(
    .DEPTH (NUM_CH),
    .WIDTH (DATA_W)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (count[ADDR_W-1:0]),
    .wdata (bus.word_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (ck_en) cksum <= bus.word_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      sum            <= '0;
      ptr            <= '0;
      tmo_cnt        <= '0;
      done_pend      <= 1'b0;
      bus.ch_addr    <= '0;
      bus.ch_data    <= '0;
      bus.ch_we      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.ch_we      <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.frame_done <= done_pend;
      done_pend      <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.word_valid && word_is_sync) begin
            state    <= RECV;
            bus.busy <= 1'b1;
            count    <= '0;
            sum      <= '0;
            tmo_cnt  <= '0;
          end
        end

        RECV: begin
          // A word arriving in the expiry cycle takes precedence over the timeout.
          if (bus.word_valid) begin
            tmo_cnt <= '0;
            if (count == FULL_CNT) begin
              state <= CHECK;
            end else if (word_is_sync) begin
              bus.frame_err <= 1'b1;
              count         <= '0;
              sum           <= '0;
            end else begin
              count <= count + 1'b1;
              sum   <= checksum_add(sum, bus.word_in);
            end
          end else if (tmo_cnt == TMO_LAST) begin
            bus.frame_err <= 1'b1;
            state         <= IDLE;
            bus.busy      <= 1'b0;
            tmo_cnt       <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        CHECK: begin
          if (cksum == sum) begin
            state <= COMMIT;
            ptr   <= '0;
          end else begin
            bus.frame_err <= 1'b1;
            state         <= IDLE;
            bus.busy      <= 1'b0;
          end
        end

        COMMIT: begin
          bus.ch_we   <= 1'b1;
          bus.ch_addr <= ptr;
          bus.ch_data <= rd_data;
          ptr         <= ptr + 1'b1;
          if (bus.word_valid) bus.frame_err <= 1'b1;
          if (ptr == LAST_PTR) begin
            state     <= IDLE;
            bus.busy  <= 1'b0;
            done_pend <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
